// File: rtl/line_arbiter_pkg.sv
// Shared definitions for the line arbiter in the memory subsystem: FSM state
// encoding and helpers that derive beat counts and index widths.
package line_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

    localparam int ADDR_BITS = 32;

    // Number of memory beats that make up one cache line.
    function automatic int beats_of(input int line_bits, input int beat_bits);
        return line_bits / beat_bits;
    endfunction

    // Width of an index able to address 'count' items (never narrower than 1).
    function automatic int idx_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/line_arbiter_rr_grant.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// requesting port found when scanning upward from ptr (wrapping around).
module rr_grant
    import line_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_BITS  = idx_bits(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_BITS-1:0]  ptr,
    output logic [NUM_PORTS-1:0] grant
);

    int   idx;
    logic found;

    // Scan ports starting at ptr and grant the first one that is requesting.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_arbiter.sv
// Line arbiter: grants one of NUM_PORTS line requesters round-robin and turns
// its line read/write into a burst of BEAT_BITS-wide memory transfers.
module line_arbiter
    import line_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]                req_read,
    input  logic [NUM_PORTS-1:0]                req_write,
    input  logic [NUM_PORTS-1:0][LINE_BITS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]                resp,
    output logic [LINE_BITS-1:0]                rdata,
    output logic [ADDR_BITS-1:0]                bmem_addr,
    output logic                                bmem_read,
    output logic                                bmem_write,
    output logic [BEAT_BITS-1:0]                bmem_wdata,
    input  logic                                bmem_ready,
    input  logic [BEAT_BITS-1:0]                bmem_rdata,
    input  logic                                bmem_rvalid
);

    localparam int BEATS     = beats_of(LINE_BITS, BEAT_BITS);
    localparam int CNT_BITS  = idx_bits(BEATS);
    localparam int PORT_BITS = idx_bits(NUM_PORTS);
    localparam logic [CNT_BITS-1:0]  LAST_BEAT = CNT_BITS'(BEATS - 1);
    localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(NUM_PORTS - 1);

    arb_state_t             state, state_next;
    logic [PORT_BITS-1:0]   rr_ptr, rr_ptr_next;
    logic [PORT_BITS-1:0]   port_sel, port_next;
    logic [CNT_BITS-1:0]    beat_cnt, beat_cnt_next;
    logic [LINE_BITS-1:0]   line_buf, line_next;
    logic [NUM_PORTS-1:0]   resp_next;
    logic [ADDR_BITS-1:0]   addr_next;
    logic                   read_next;
    logic                   write_next;
    logic [BEAT_BITS-1:0]   wdata_next;
    logic [NUM_PORTS-1:0]   req_any;
    logic [NUM_PORTS-1:0]   grant;
    logic [PORT_BITS-1:0]   grant_idx;

    assign req_any = req_read | req_write;
    assign rdata   = line_buf;

    rr_grant #(
        .NUM_PORTS(NUM_PORTS),
        .PTR_BITS (PORT_BITS)
    ) u_rr_grant (
        .req  (req_any),
        .ptr  (rr_ptr),
        .grant(grant)
    );

    // Convert the one-hot grant into a port index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                grant_idx = PORT_BITS'(i);
            end
        end
    end

    // Next-state and next-output logic; every output is registered next cycle.
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        port_next     = port_sel;
        beat_cnt_next = beat_cnt;
        line_next     = line_buf;
        resp_next     = '0;
        addr_next     = bmem_addr;
        read_next     = bmem_read;
        write_next    = bmem_write;
        wdata_next    = bmem_wdata;
        unique case (state)
            IDLE: begin
                if (|req_any) begin
                    port_next     = grant_idx;
                    addr_next     = req_addr[grant_idx];
                    beat_cnt_next = '0;
                    if (req_write[grant_idx]) begin
                        state_next = WRITE;
                        write_next = 1'b1;
                        line_next  = req_wdata[grant_idx];
                        wdata_next = req_wdata[grant_idx][BEAT_BITS-1:0];
                    end else begin
                        state_next = READ_WAIT;
                        read_next  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bmem_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_next          = RESP;
                        write_next          = 1'b0;
                        beat_cnt_next       = '0;
                        resp_next[port_sel] = 1'b1;
                        rr_ptr_next         = (port_sel == LAST_PORT) ? '0 : port_sel + 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                        wdata_next    = line_buf[(int'(beat_cnt) + 1) * BEAT_BITS +: BEAT_BITS];
                    end
                end
            end
            READ_WAIT: begin
                if (bmem_read) begin
                    if (bmem_ready) begin
                        read_next = 1'b0;
                    end
                end else if (bmem_rvalid) begin
                    line_next[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    if (beat_cnt == LAST_BEAT) begin
                        state_next          = RESP;
                        beat_cnt_next       = '0;
                        resp_next[port_sel] = 1'b1;
                        rr_ptr_next         = (port_sel == LAST_PORT) ? '0 : port_sel + 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            port_sel   <= '0;
            beat_cnt   <= '0;
            line_buf   <= '0;
            resp       <= '0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_ptr_next;
            port_sel   <= port_next;
            beat_cnt   <= beat_cnt_next;
            line_buf   <= line_next;
            resp       <= resp_next;
            bmem_addr  <= addr_next;
            bmem_read  <= read_next;
            bmem_write <= write_next;
            bmem_wdata <= wdata_next;
        end
    end

endmodule

// File: tb/tb_line_arbiter.sv
// Scoreboard bench for line_arbiter: a 2-port instance with a behavioural
// memory and a 4-port instance for round-robin ordering.
module tb_line_arbiter;

    localparam int BEATS = 4;
    localparam int K     = 2;

    typedef struct {
        int           port;
        bit           is_read;
        logic [255:0] line;
        int           at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0][31:0]  a_req_addr;
    logic [1:0]        a_req_read;
    logic [1:0]        a_req_write;
    logic [1:0][255:0] a_req_wdata;
    logic [1:0]        a_resp;
    logic [255:0]      a_rdata;
    logic [31:0]       a_bmem_addr;
    logic              a_bmem_read;
    logic              a_bmem_write;
    logic [63:0]       a_bmem_wdata;
    logic              a_bmem_ready;
    logic [63:0]       a_bmem_rdata;
    logic              a_bmem_rvalid;

    logic [3:0][31:0]  b_req_addr;
    logic [3:0]        b_req_read;
    logic [3:0]        b_req_write;
    logic [3:0][255:0] b_req_wdata;
    logic [3:0]        b_resp;
    logic [255:0]      b_rdata;
    logic [31:0]       b_bmem_addr;
    logic              b_bmem_read;
    logic              b_bmem_write;
    logic [63:0]       b_bmem_wdata;

    exp_t        a_exp[$];
    exp_t        b_exp[$];
    logic [31:0] a_exp_addr[$];
    logic [63:0] a_exp_wbeat[$];
    logic [63:0] a_rd_beats[$];
    bit          a_stray;
    logic [63:0] a_stray_val;
    int          a_stall_beat;
    int          a_stall_left;

    line_arbiter #(.NUM_PORTS(2), .LINE_BITS(256), .BEAT_BITS(64)) dut_a (
        .clk(clk), .rst(rst),
        .req_addr(a_req_addr), .req_read(a_req_read), .req_write(a_req_write),
        .req_wdata(a_req_wdata), .resp(a_resp), .rdata(a_rdata),
        .bmem_addr(a_bmem_addr), .bmem_read(a_bmem_read), .bmem_write(a_bmem_write),
        .bmem_wdata(a_bmem_wdata), .bmem_ready(a_bmem_ready),
        .bmem_rdata(a_bmem_rdata), .bmem_rvalid(a_bmem_rvalid)
    );

    line_arbiter #(.NUM_PORTS(4), .LINE_BITS(256), .BEAT_BITS(64)) dut_b (
        .clk(clk), .rst(rst),
        .req_addr(b_req_addr), .req_read(b_req_read), .req_write(b_req_write),
        .req_wdata(b_req_wdata), .resp(b_resp), .rdata(b_rdata),
        .bmem_addr(b_bmem_addr), .bmem_read(b_bmem_read), .bmem_write(b_bmem_write),
        .bmem_wdata(b_bmem_wdata), .bmem_ready(1'b1),
        .bmem_rdata(64'd0), .bmem_rvalid(1'b0)
    );

    task automatic check_output(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_exp_a(input int port, input bit is_read, input logic [255:0] line, input int at);
        exp_t e;
        e.port = port; e.is_read = is_read; e.line = line; e.at = at;
        a_exp.push_back(e);
    endtask

    task automatic push_exp_b(input int port, input int at);
        exp_t e;
        e.port = port; e.is_read = 1'b0; e.line = '0; e.at = at;
        b_exp.push_back(e);
    endtask

    task automatic apply_request_a(input int port, input bit rd, input bit wr,
                                   input logic [31:0] addr, input logic [255:0] wline);
        a_req_addr[port]  = addr;
        a_req_wdata[port] = wline;
        a_req_read[port]  = rd;
        a_req_write[port] = wr;
    endtask

    task automatic wait_resp_a(input int port, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_resp[port] && n < limit);
        if (!a_resp[port]) begin
            total++; bad++;
            $display("[TB] FAIL a_timeout_port%0d: got no resp want resp within %0d cycles", port, limit);
        end
        a_req_read[port]  = 1'b0;
        a_req_write[port] = 1'b0;
    endtask

    task automatic wait_resp_b(input int port, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_resp[port] && n < limit);
        if (!b_resp[port]) begin
            total++; bad++;
            $display("[TB] FAIL b_timeout_port%0d: got no resp want resp within %0d cycles", port, limit);
        end
        b_req_write[port] = 1'b0;
    endtask

    // Behavioural memory for instance A: decides ready/rvalid for the coming
    // edge from the outputs visible now, and checks every accepted command/beat.
    initial begin : mem_a
        int wait_cnt;
        int stream;
        int wacc;
        wait_cnt = 0; stream = 0; wacc = 0;
        a_bmem_ready = 1'b1; a_bmem_rvalid = 1'b0; a_bmem_rdata = '0;
        forever begin
            @(negedge clk);
            a_bmem_rvalid = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) stream = BEATS;
            end
            if (stream > 0) begin
                a_bmem_rvalid = 1'b1;
                a_bmem_rdata  = (a_rd_beats.size() > 0) ? a_rd_beats.pop_front() : 64'hDEAD;
                stream--;
            end else if (a_stray) begin
                a_bmem_rvalid = 1'b1;
                a_bmem_rdata  = a_stray_val;
                a_stray       = 1'b0;
            end
            a_bmem_ready = 1'b1;
            if (a_bmem_write === 1'b1) begin
                if (wacc == a_stall_beat && a_stall_left > 0) begin
                    a_bmem_ready = 1'b0;
                    a_stall_left--;
                    if (a_exp_wbeat.size() > 0) check_output("a_wdata_hold", a_bmem_wdata, a_exp_wbeat[0]);
                end else begin
                    if (wacc == 0) begin
                        if (a_exp_addr.size() > 0) check_output("a_write_addr", a_bmem_addr, a_exp_addr.pop_front());
                        else check_output("a_write_addr_unexpected", a_bmem_addr, 'x);
                    end
                    if (a_exp_wbeat.size() > 0) check_output("a_wbeat", a_bmem_wdata, a_exp_wbeat.pop_front());
                    else check_output("a_wbeat_unexpected", a_bmem_wdata, 'x);
                    wacc = (wacc == BEATS - 1) ? 0 : wacc + 1;
                end
            end
            if (a_bmem_read === 1'b1) begin
                if (a_exp_addr.size() > 0) check_output("a_read_addr", a_bmem_addr, a_exp_addr.pop_front());
                else check_output("a_read_addr_unexpected", a_bmem_addr, 'x);
                wait_cnt = K;
                check_output("a_read_write_exclusive", a_bmem_write, 1'b0);
            end
        end
    end

    // Response monitor for instance A.
    initial begin : mon_a
        exp_t       e;
        logic [1:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (a_resp != 0) begin
                if (a_exp.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL a_resp_unexpected: got %b want none", a_resp);
                end else begin
                    e = a_exp.pop_front();
                    check_output("a_resp_port", a_resp, 256'(1) << e.port);
                    if (e.is_read) check_output("a_rdata", a_rdata, e.line);
                    if (e.at >= 0) check_output("a_resp_cycle", cyc, e.at);
                end
                check_output("a_resp_back_to_back", a_resp & prev, 0);
            end
            prev = a_resp;
        end
    end

    // Response monitor for instance B.
    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_resp != 0) begin
                if (b_exp.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL b_resp_unexpected: got %b want none", b_resp);
                end else begin
                    e = b_exp.pop_front();
                    check_output("b_resp_port", b_resp, 256'(1) << e.port);
                    if (e.at >= 0) check_output("b_resp_cycle", cyc, e.at);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin : stim
        bit saw;
        rst = 1'b1;
        a_req_addr = '0; a_req_read = '0; a_req_write = '0; a_req_wdata = '0;
        b_req_addr = '0; b_req_read = '0; b_req_write = '0; b_req_wdata = '0;
        a_stray = 1'b0; a_stray_val = '0; a_stall_beat = -1; a_stall_left = 0;

        repeat (3) @(negedge clk);
        check_output("rst_resp", a_resp, 0);
        check_output("rst_bmem_read", a_bmem_read, 0);
        check_output("rst_bmem_write", a_bmem_write, 0);
        check_output("rst_bmem_addr", a_bmem_addr, 0);
        check_output("rst_bmem_wdata", a_bmem_wdata, 0);
        check_output("rst_rdata", a_rdata, 0);
        check_output("rst_b_resp", b_resp, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] port0 read 0x1000");
        a_rd_beats.push_back(64'hA0); a_rd_beats.push_back(64'hA1);
        a_rd_beats.push_back(64'hA2); a_rd_beats.push_back(64'hA3);
        a_exp_addr.push_back(32'h1000);
        push_exp_a(0, 1'b1, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, cyc + 7);
        apply_request_a(0, 1'b1, 1'b0, 32'h1000, '0);
        wait_resp_a(0, 40);
        @(negedge clk);

        $display("[TB] port1 write 0x2000 with stalled second beat");
        a_stall_beat = 1; a_stall_left = 3;
        a_exp_wbeat.push_back(64'hD0); a_exp_wbeat.push_back(64'hD1);
        a_exp_wbeat.push_back(64'hD2); a_exp_wbeat.push_back(64'hD3);
        a_exp_addr.push_back(32'h2000);
        push_exp_a(1, 1'b0, '0, cyc + 8);
        apply_request_a(1, 1'b0, 1'b1, 32'h2000, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
        wait_resp_a(1, 40);
        @(negedge clk);

        $display("[TB] both ports requesting continuously");
        a_rd_beats.push_back(64'hB0); a_rd_beats.push_back(64'hB1);
        a_rd_beats.push_back(64'hB2); a_rd_beats.push_back(64'hB3);
        a_rd_beats.push_back(64'hC0); a_rd_beats.push_back(64'hC1);
        a_rd_beats.push_back(64'hC2); a_rd_beats.push_back(64'hC3);
        for (int t = 0; t < 2; t++) begin
            a_exp_addr.push_back(32'h3000);
            a_exp_addr.push_back(32'h4000);
            a_exp_wbeat.push_back(64'h50); a_exp_wbeat.push_back(64'h51);
            a_exp_wbeat.push_back(64'h52); a_exp_wbeat.push_back(64'h53);
        end
        push_exp_a(0, 1'b1, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, -1);
        push_exp_a(1, 1'b0, '0, -1);
        push_exp_a(0, 1'b1, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, -1);
        push_exp_a(1, 1'b0, '0, -1);
        apply_request_a(0, 1'b1, 1'b0, 32'h3000, '0);
        apply_request_a(1, 1'b0, 1'b1, 32'h4000, {64'h53, 64'h52, 64'h51, 64'h50});
        begin
            int got;
            int n;
            got = 0; n = 0;
            while (got < 4 && n < 200) begin
                @(negedge clk);
                n++;
                if (a_resp != 0) got++;
            end
            a_req_read = '0; a_req_write = '0;
            check_output("a_alternate_resp_count", got, 4);
        end
        @(negedge clk);

        $display("[TB] reset during a read");
        a_rd_beats.push_back(64'hE0); a_rd_beats.push_back(64'hE1);
        a_rd_beats.push_back(64'hE2); a_rd_beats.push_back(64'hE3);
        a_exp_addr.push_back(32'h5000);
        apply_request_a(0, 1'b1, 1'b0, 32'h5000, '0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        a_req_read = '0;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_mid_resp", a_resp, 0);
        check_output("rst_mid_bmem_read", a_bmem_read, 0);
        check_output("rst_mid_bmem_write", a_bmem_write, 0);
        check_output("rst_mid_bmem_addr", a_bmem_addr, 0);
        check_output("rst_mid_bmem_wdata", a_bmem_wdata, 0);
        check_output("rst_mid_rdata", a_rdata, 0);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_resp != 0) saw = 1'b1;
        end
        check_output("a_no_resp_after_rst", saw, 0);

        $display("[TB] port1 read 0x6000 after reset");
        a_rd_beats.push_back(64'hF0); a_rd_beats.push_back(64'hF1);
        a_rd_beats.push_back(64'hF2); a_rd_beats.push_back(64'hF3);
        a_exp_addr.push_back(32'h6000);
        push_exp_a(1, 1'b1, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, cyc + 7);
        apply_request_a(1, 1'b1, 1'b0, 32'h6000, '0);
        wait_resp_a(1, 40);
        @(negedge clk);

        $display("[TB] stray rvalid then read+write on port0");
        a_stray_val = 64'hEE; a_stray = 1'b1;
        repeat (3) @(negedge clk);
        a_exp_wbeat.push_back(64'h70); a_exp_wbeat.push_back(64'h71);
        a_exp_wbeat.push_back(64'h72); a_exp_wbeat.push_back(64'h73);
        a_exp_addr.push_back(32'h7000);
        push_exp_a(0, 1'b0, '0, cyc + 5);
        apply_request_a(0, 1'b1, 1'b1, 32'h7000, {64'h73, 64'h72, 64'h71, 64'h70});
        wait_resp_a(0, 40);
        a_stray_val = 64'hEF; a_stray = 1'b1;
        repeat (3) @(negedge clk);
        a_rd_beats.push_back(64'h90); a_rd_beats.push_back(64'h91);
        a_rd_beats.push_back(64'h92); a_rd_beats.push_back(64'h93);
        a_exp_addr.push_back(32'h8000);
        push_exp_a(0, 1'b1, {64'h93, 64'h92, 64'h91, 64'h90}, cyc + 7);
        apply_request_a(0, 1'b1, 1'b0, 32'h8000, '0);
        wait_resp_a(0, 40);
        @(negedge clk);

        $display("[TB] 4-port round robin from pointer 2");
        push_exp_b(1, cyc + 5);
        b_req_addr[1] = 32'h100; b_req_write[1] = 1'b1;
        wait_resp_b(1, 40);
        @(negedge clk);
        push_exp_b(3, cyc + 5);
        push_exp_b(1, cyc + 11);
        b_req_addr[3] = 32'h300; b_req_write[3] = 1'b1;
        b_req_addr[1] = 32'h140; b_req_write[1] = 1'b1;
        wait_resp_b(3, 40);
        wait_resp_b(1, 40);

        repeat (4) @(negedge clk);
        check_output("a_exp_left", a_exp.size(), 0);
        check_output("a_addr_left", a_exp_addr.size(), 0);
        check_output("a_wbeat_left", a_exp_wbeat.size(), 0);
        check_output("a_rbeat_left", a_rd_beats.size(), 0);
        check_output("b_exp_left", b_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
